fp_mant_multiplier: RTL and testbench

//  Sequential shift-add mantissa/exponent core of the single-precision FP multiplier.

---
 rtl/fp_mant_multiplier_if.sv | 26 ++
 rtl/fp_mant_multiplier.sv | 132 +++++++++++++
 tb/tb_fp_mant_multiplier.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_mant_multiplier_if.sv
// Operand/result bundle between the FP multiplier front end and the mantissa core.
// The master side issues start with operands; the slave side returns the raw product and exponent.
interface fp_mant_multiplier_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic                  i_start;
    logic [31:0]           i_a;
    logic [31:0]           i_b;
    logic                  o_busy;
    logic                  o_done;
    logic [2*MANT_W-1:0]   o_result_mul;
    logic [EXP_W+1:0]      o_rexp;
    logic [31:0]           o_op_a;
    logic [31:0]           o_op_b;

    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_result_mul, o_rexp, o_op_a, o_op_b
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_result_mul, o_rexp, o_op_a, o_op_b
    );
endinterface

// File: rtl/fp_mant_multiplier.sv
// Shift-add 24x24 mantissa multiplier with unbiased exponent sum for single-precision FP.
// Optional ZERO_BYPASS_EN: a zero operand skips the multiply loop and returns a zero result.
//
// state | meaning
// IDLE  | waiting for start; latches operands, restores hidden bits
// LOAD  | forms Ea+Eb-2*BIAS, clears iteration counter
// MUL   | one partial-product add and right shift per cycle, MANT_W cycles
// DONE  | one-cycle done pulse, results held
module fp_mant_multiplier #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = 127
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    fp_mant_multiplier_if.slave   bus
);
    localparam int FRAC_W = MANT_W - 1;
    localparam int REXP_W = EXP_W + 2;
    localparam int CNT_W  = $clog2(MANT_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_busy;
    logic                  r_done;
    logic [31:0]           r_op_a;
    logic [31:0]           r_op_b;
    logic [MANT_W-1:0]     r_m;
    logic [MANT_W-1:0]     r_q;
    logic [MANT_W-1:0]     r_p_hi;
    logic                  r_c;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*MANT_W-1:0]   r_result;
    logic [REXP_W-1:0]     r_rexp;

    logic [MANT_W-1:0]     w_addend;
    logic [MANT_W:0]       w_sum;
    logic [REXP_W-1:0]     w_rexp;

    assign w_addend = r_q[0] ? r_m : '0;
    assign w_sum    = {r_c, r_p_hi} + {1'b0, w_addend};
    // Two's complement wrap at REXP_W bits is intended; downstream reads it as signed.
    assign w_rexp   = {2'b00, r_op_a[FRAC_W +: EXP_W]} + {2'b00, r_op_b[FRAC_W +: EXP_W]}
                      - REXP_W'(2 * BIAS);

`ifdef ZERO_BYPASS_EN
    logic w_zero_op;
    assign w_zero_op = (r_op_a[30:0] == 31'd0) || (r_op_b[30:0] == 31'd0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_m      <= '0;
            r_q      <= '0;
            r_p_hi   <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_rexp   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_op_a  <= bus.i_a;
                        r_op_b  <= bus.i_b;
                        r_m     <= {1'b1, bus.i_a[FRAC_W-1:0]};
                        r_q     <= {1'b1, bus.i_b[FRAC_W-1:0]};
                        r_p_hi  <= '0;
                        r_c     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
`ifdef ZERO_BYPASS_EN
                    if (w_zero_op) begin
                        r_result <= '0;
                        r_rexp   <= '0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_rexp  <= w_rexp;
                        r_state <= S_MUL;
                    end
`else
                    r_rexp  <= w_rexp;
                    r_state <= S_MUL;
`endif
                end
                S_MUL: begin
                    // Sum's LSB shifts into Q; the carry lands in P_hi's MSB, so C returns to 0.
                    {r_c, r_p_hi, r_q} <= {1'b0, w_sum, r_q[MANT_W-1:1]};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_result <= {w_sum, r_q[MANT_W-1:1]};
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_result_mul = r_result;
    assign bus.o_rexp       = r_rexp;
    assign bus.o_op_a       = r_op_a;
    assign bus.o_op_b       = r_op_b;
endmodule

// File: tb/tb_fp_mant_multiplier.sv
// Directed-vector bench for fp_mant_multiplier: expected results are queued at issue and
// compared by an independent monitor whenever done is seen.
module tb_fp_mant_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [47:0] res;
        logic [9:0]  rexp;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    fp_mant_multiplier_if #(.MANT_W(24), .EXP_W(8)) bus ();

    fp_mant_multiplier #(.MANT_W(24), .EXP_W(8), .BIAS(127)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.o_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_mul", 64'(bus.o_result_mul), 64'(e.res));
                chk("rexp",       64'(bus.o_rexp),       64'(e.rexp));
                chk("op_a",       64'(bus.o_op_a),       64'(e.a));
                chk("op_b",       64'(bus.o_op_b),       64'(e.b));
                chk("done_cycle", 64'(cyc),              64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [47:0] res,
                         input logic [9:0] rexp, input int lat, input bit push);
        exp_t e;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk("accept_busy", 64'(bus.o_busy), 64'd1);
        if (push) begin
            e.res  = res;
            e.rexp = rexp;
            e.a    = a;
            e.b    = b;
            e.cyc  = cyc + lat;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (bus.o_done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            chk({name, "_timeout"}, 64'(n), 64'd0);
        end else begin
            @(negedge clk);
            chk({name, "_busy_after_done"}, 64'(bus.o_busy), 64'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=%0d required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int zlat;
        logic [47:0] zres;
        logic [9:0]  zrexp;

        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   64'(bus.o_busy),       64'd0);
        chk("rst_done",   64'(bus.o_done),       64'd0);
        chk("rst_result", 64'(bus.o_result_mul), 64'd0);
        chk("rst_rexp",   64'(bus.o_rexp),       64'd0);
        chk("rst_op_a",   64'(bus.o_op_a),       64'd0);
        chk("rst_op_b",   64'(bus.o_op_b),       64'd0);
        rst = 1'b0;

        issue(32'h3F80_0000, 32'h3F80_0000, 48'h4000_0000_0000, 10'd0,     25, 1'b1);
        wait_done("one_x_one");
        issue(32'h3FC0_0000, 32'h3FC0_0000, 48'h9000_0000_0000, 10'd0,     25, 1'b1);
        wait_done("onehalf_sq");
        issue(32'h4000_0000, 32'h4040_0000, 48'h6000_0000_0000, 10'd2,     25, 1'b1);
        wait_done("two_x_three");
        issue(32'h3E80_0000, 32'h3F80_0000, 48'h4000_0000_0000, 10'h3FE,   25, 1'b1);
        wait_done("quarter");
        issue(32'h7F7F_FFFF, 32'h7F7F_FFFF, 48'hFFFF_FE00_0001, 10'h0FE,   25, 1'b1);
        wait_done("max_mant");
        issue(32'h3F80_0001, 32'h3F80_0003, 48'h4000_0200_0003, 10'd0,     25, 1'b1);
        wait_done("low_bits");

        // Starts during the busy window must be ignored; a start held in DONE waits for IDLE.
        issue(32'h4000_0000, 32'h4040_0000, 48'h6000_0000_0000, 10'd2,     25, 1'b1);
        k = cyc;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = 32'h4040_0000;
        bus.i_b     = 32'h3E80_0000;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        while (cyc != k + 24) @(negedge clk);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        @(negedge clk);
        chk("busy_op_done_now", 64'(bus.o_done), 64'd1);
        bus.i_start = 1'b1;
        bus.i_a     = 32'h3FC0_0000;
        bus.i_b     = 32'h3FC0_0000;
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", 64'(bus.o_busy), 64'd0);
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        chk("start_after_done_taken", 64'(bus.o_busy), 64'd1);
        begin
            exp_t e;
            e.res  = 48'h9000_0000_0000;
            e.rexp = 10'd0;
            e.a    = 32'h3FC0_0000;
            e.b    = 32'h3FC0_0000;
            e.cyc  = cyc + 25;
            sb.push_back(e);
        end
        wait_done("after_done_start");

        // Reset during the multiply loop aborts with no done pulse.
        issue(32'h3F80_0000, 32'h4040_0000, 48'h0, 10'd0, 25, 1'b0);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy",   64'(bus.o_busy),       64'd0);
        chk("midrst_done",   64'(bus.o_done),       64'd0);
        chk("midrst_result", 64'(bus.o_result_mul), 64'd0);
        chk("midrst_rexp",   64'(bus.o_rexp),       64'd0);
        chk("midrst_op_a",   64'(bus.o_op_a),       64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrst_no_done", 64'(sb.size()), 64'd0);
        issue(32'h3F80_0000, 32'h4040_0000, 48'h6000_0000_0000, 10'd1,     25, 1'b1);
        wait_done("post_reset");

`ifdef ZERO_BYPASS_EN
        zlat  = 1;
        zres  = 48'h0;
        zrexp = 10'd0;
`else
        zlat  = 25;
        zres  = 48'h4000_0000_0000;
        zrexp = 10'h381;
`endif
        issue(32'h0000_0000, 32'h3F80_0000, zres, zrexp, zlat, 1'b1);
        wait_done("zero_op");

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
